// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multi-cycle execute stage (ALU, shifts, signed multiply, optional iterative divider).
// Optional feature macro: EXEC_DIV_EN compiles in the restoring divider; without it DIV/DIVU are illegal.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready              operation handshake (op, dst, dst2, opa, opb, cin)
//   out_valid/out_ready            result handshake
//   result, result2                primary / secondary results
//   out_dst, out_dst2              registered destination numbers
//   out_we, out_we2                result write enables
//   flags_o, flags_we              {CY, OV, S, Z} values and per-flag update mask
//   out_illegal                    op unsupported
//   busy                           divider iterating
module exec_unit_mc #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned REGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [REGW-1:0] dst,
   input  logic [REGW-1:0] dst2,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   input  logic            cin,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] result2,
   output logic [REGW-1:0] out_dst,
   output logic [REGW-1:0] out_dst2,
   output logic            out_we,
   output logic            out_we2,
   output logic [3:0]      flags_o,
   output logic [3:0]      flags_we,
   output logic            out_illegal,
   output logic            busy
);
   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned M   = XLEN - 1;
   localparam logic [3:0] OP_MOV = 4'd0,  OP_ADD = 4'd1,  OP_ADDC = 4'd2,  OP_SUB  = 4'd3;
   localparam logic [3:0] OP_CMP = 4'd4,  OP_AND = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_SAR  = 4'd10, OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV = 4'd12, OP_DIVU = 4'd13;

   logic              accept;
   logic [SHW-1:0]    sh;
   logic [XLEN:0]     sum, diff, shl_w, shr_w, sar_w;
   logic signed [XLEN:0] sar_src;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   c_res, c_res2;
   logic [3:0]        c_flags, c_fwe;
   logic              c_we, c_we2, c_ill, c_div_start;

   assign accept  = in_valid && in_ready;
   assign in_ready = !busy && (!out_valid || out_ready);
   assign sh      = opa[SHW-1:0];
   assign sum     = {1'b0, opb} + {1'b0, opa} + (XLEN+1)'(cin && (op == OP_ADDC));
   assign diff    = {1'b0, opb} - {1'b0, opa};
   // Extra bit beyond the word catches the last bit shifted out (0 for a zero amount).
   assign shl_w   = {1'b0, opb} << sh;
   assign shr_w   = {opb, 1'b0} >> sh;
   assign sar_src = {opb, 1'b0};
   assign sar_w   = sar_src >>> sh;
   assign prod    = {{XLEN{opb[M]}}, opb} * {{XLEN{opa[M]}}, opa};

`ifdef EXEC_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} div_state_t;
   localparam int unsigned CW = $clog2(XLEN + 1);
   div_state_t     state;
   logic [CW-1:0]  count;
   logic [XLEN-1:0] rem, quo, dvs, dsub, mag_a, mag_b, q_fix, r_fix;
   logic [XLEN:0]  dshift;
   logic           d_ge, a_neg, b_neg, q_neg, r_neg, busy_q;

   assign busy   = busy_q;
   assign a_neg  = (op == OP_DIV) && opa[M];
   assign b_neg  = (op == OP_DIV) && opb[M];
   assign mag_a  = a_neg ? -opa : opa;
   assign mag_b  = b_neg ? -opb : opb;
   // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
   assign dshift = {rem, quo[M]};
   assign d_ge   = dshift >= {1'b0, dvs};
   assign dsub   = dshift[XLEN-1:0] - dvs;
   assign q_fix  = q_neg ? -quo : quo;
   assign r_fix  = r_neg ? -rem : rem;
`else
   assign busy = 1'b0;
`endif

   // Single-cycle result, flags and divider launch decision.
   always_comb begin
      c_res = '0; c_res2 = '0; c_flags = '0; c_fwe = '0;
      c_we = 1'b0; c_we2 = 1'b0; c_ill = 1'b0; c_div_start = 1'b0;
      case (op)
         OP_MOV: begin c_res = opa; c_we = 1'b1; end
         OP_ADD, OP_ADDC: begin
            c_res = sum[XLEN-1:0]; c_we = 1'b1; c_fwe = 4'b1111;
            c_flags[3] = sum[XLEN];
            c_flags[2] = (opb[M] == opa[M]) && (sum[M] != opb[M]);
         end
         OP_SUB, OP_CMP: begin
            c_res = diff[XLEN-1:0]; c_we = (op == OP_SUB); c_fwe = 4'b1111;
            c_flags[3] = diff[XLEN];
            c_flags[2] = (opb[M] != opa[M]) && (diff[M] != opb[M]);
         end
         OP_AND: begin c_res = opb & opa; c_we = 1'b1; c_fwe = 4'b0111; end
         OP_OR:  begin c_res = opb | opa; c_we = 1'b1; c_fwe = 4'b0111; end
         OP_XOR: begin c_res = opb ^ opa; c_we = 1'b1; c_fwe = 4'b0111; end
         OP_SHL: begin {c_flags[3], c_res} = shl_w; c_we = 1'b1; c_fwe = 4'b1111; end
         OP_SHR: begin {c_res, c_flags[3]} = shr_w; c_we = 1'b1; c_fwe = 4'b1111; end
         OP_SAR: begin {c_res, c_flags[3]} = sar_w; c_we = 1'b1; c_fwe = 4'b1111; end
         OP_MUL: begin
            {c_res2, c_res} = prod; c_we = 1'b1; c_we2 = 1'b1;
         end
`ifdef EXEC_DIV_EN
         OP_DIV, OP_DIVU: begin
            c_we = 1'b1; c_we2 = 1'b1; c_fwe = 4'b0111;
            if (opa == '0) begin
               c_res2 = opb; c_flags[2] = 1'b1;
            end else if ((op == OP_DIV) && (opb == {1'b1, {M{1'b0}}}) && (&opa)) begin
               c_res = opb; c_flags[2] = 1'b1;
            end else begin
               c_div_start = 1'b1;
            end
         end
`else
         OP_DIV, OP_DIVU: c_ill = 1'b1;
`endif
         default: c_ill = 1'b1;
      endcase
      if (c_fwe != 4'b0000) begin
         c_flags[1] = c_res[M];
         c_flags[0] = (c_res == '0);
      end
   end

   // Output register, handshake and divider state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0; result <= '0; result2 <= '0;
         out_dst <= '0; out_dst2 <= '0; out_we <= 1'b0; out_we2 <= 1'b0;
         flags_o <= '0; flags_we <= '0; out_illegal <= 1'b0;
`ifdef EXEC_DIV_EN
         state <= S_IDLE; busy_q <= 1'b0; count <= '0;
         rem <= '0; quo <= '0; dvs <= '0; q_neg <= 1'b0; r_neg <= 1'b0;
`endif
      end else begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (accept) begin
            out_valid   <= !c_div_start;
            result      <= c_res;
            result2     <= c_res2;
            out_dst     <= dst;
            out_dst2    <= dst2;
            out_we      <= c_we;
            out_we2     <= c_we2;
            flags_o     <= c_flags;
            flags_we    <= c_fwe;
            out_illegal <= c_ill;
`ifdef EXEC_DIV_EN
            if (c_div_start) begin
               state <= S_RUN; busy_q <= 1'b1; count <= '0;
               rem <= '0; quo <= mag_b; dvs <= mag_a;
               q_neg <= a_neg ^ b_neg; r_neg <= b_neg;
            end else begin
               state <= S_IDLE;
            end
`endif
         end
`ifdef EXEC_DIV_EN
         else begin
            case (state)
               S_RUN: begin
                  rem   <= d_ge ? dsub : dshift[XLEN-1:0];
                  quo   <= {quo[XLEN-2:0], d_ge};
                  count <= count + CW'(1);
                  if (count == CW'(XLEN - 1)) state <= S_FIX;
               end
               S_FIX: begin
                  result    <= q_fix;
                  result2   <= r_fix;
                  flags_o   <= {2'b00, q_fix[M], q_fix == '0};
                  out_valid <= 1'b1;
                  busy_q    <= 1'b0;
                  state     <= S_DONE;
               end
               S_DONE: if (out_ready) state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
`endif
      end
   end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: table-driven directed bench for exec_unit_mc plus handshake, divider and reset sequences.
module tb_exec_unit_mc;
   localparam int unsigned XLEN = 32;
   localparam int unsigned REGW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready, cin, out_valid, out_ready;
   logic [3:0]      op;
   logic [REGW-1:0] dst, dst2, out_dst, out_dst2;
   logic [XLEN-1:0] opa, opb, result, result2;
   logic            out_we, out_we2, out_illegal, busy;
   logic [3:0]      flags_o, flags_we;

   int n_cmp  = 0;
   int n_fail = 0;

   exec_unit_mc #(.XLEN(XLEN), .REGW(REGW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .dst(dst), .dst2(dst2), .opa(opa), .opb(opb), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .result2(result2),
      .out_dst(out_dst), .out_dst2(out_dst2), .out_we(out_we), .out_we2(out_we2),
      .flags_o(flags_o), .flags_we(flags_we), .out_illegal(out_illegal), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] opb, opa;
      logic        cin;
      logic [31:0] r, r2;
      logic        we, we2;
      logic [3:0]  fl, fwe;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] o, input logic [31:0] b, input logic [31:0] a,
                               input logic c, input logic [31:0] r, input logic [31:0] r2,
                               input logic we, input logic we2, input logic [3:0] fl,
                               input logic [3:0] fwe, input logic ill);
      vec_t v;
      v.op = o; v.opb = b; v.opa = a; v.cin = c; v.r = r; v.r2 = r2;
      v.we = we; v.we2 = we2; v.fl = fl; v.fwe = fwe; v.ill = ill;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer one op at the falling edge; it is accepted on the next rising edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] b, input logic [31:0] a,
                        input logic c, input logic [4:0] d, input logic [4:0] d2);
      @(negedge clk);
      check("in_ready before issue", 64'(in_ready), 64'd1);
      op = o; opb = b; opa = a; cin = c; dst = d; dst2 = d2; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [31:0] r, input logic [31:0] r2,
                            input logic we, input logic we2, input logic [3:0] fl,
                            input logic [3:0] fwe, input logic ill, input logic [4:0] d,
                            input logic [4:0] d2);
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " result"}, 64'(result), 64'(r));
      check({tag, " result2"}, 64'(result2), 64'(r2));
      check({tag, " out_we"}, 64'(out_we), 64'(we));
      check({tag, " out_we2"}, 64'(out_we2), 64'(we2));
      check({tag, " flags_o"}, 64'(flags_o), 64'(fl));
      check({tag, " flags_we"}, 64'(flags_we), 64'(fwe));
      check({tag, " out_illegal"}, 64'(out_illegal), 64'(ill));
      check({tag, " out_dst"}, 64'(out_dst), 64'(d));
      if (we2) check({tag, " out_dst2"}, 64'(out_dst2), 64'(d2));
   endtask

`ifdef EXEC_DIV_EN
   // Normal-path divide: busy during RUN, result exactly XLEN+1 cycles after accept.
   task automatic run_div(input string tag, input logic [3:0] o, input logic [31:0] b,
                          input logic [31:0] a, input logic [31:0] q, input logic [31:0] r,
                          input logic [3:0] fl);
      int cycles;
      issue(o, b, a, 1'b0, 5'd3, 5'd4);
      check({tag, " busy after accept"}, 64'(busy), 64'd1);
      check({tag, " in_ready while busy"}, 64'(in_ready), 64'd0);
      check({tag, " out_valid during run"}, 64'(out_valid), 64'd0);
      opa = 32'h0000_0001; opb = 32'hDEAD_BEEF; op = 4'd1;
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (!out_valid && cycles < 100);
      check({tag, " latency"}, 64'(cycles), 64'(XLEN + 1));
      check({tag, " busy at done"}, 64'(busy), 64'd0);
      check_out(tag, q, r, 1'b1, 1'b1, fl, 4'b0111, 1'b0, 5'd3, 5'd4);
   endtask
`endif

   initial begin
      int stale;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; opa = '0; opb = '0;
      cin = 1'b0; dst = '0; dst2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset result2", 64'(result2), 64'd0);
      check("reset flags_o", 64'(flags_o), 64'd0);
      check("reset flags_we", 64'(flags_we), 64'd0);
      check("reset out_we", 64'(out_we), 64'd0);
      check("reset out_we2", 64'(out_we2), 64'd0);
      check("reset out_illegal", 64'(out_illegal), 64'd0);
      check("reset out_dst", 64'(out_dst), 64'd0);
      check("reset out_dst2", 64'(out_dst2), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      //                op     opb           opa           cin  result        result2       we  we2 flags    fwe      ill
      vecs.push_back(mk(4'd1,  32'h7FFFFFFF, 32'h00000001, 0, 32'h80000000, 32'h0,        1,  0, 4'b0110, 4'b1111, 0));
      vecs.push_back(mk(4'd4,  32'h00000003, 32'h00000005, 0, 32'hFFFFFFFE, 32'h0,        0,  0, 4'b1010, 4'b1111, 0));
      vecs.push_back(mk(4'd10, 32'h80000001, 32'h00000001, 0, 32'hC0000000, 32'h0,        1,  0, 4'b1010, 4'b1111, 0));
      vecs.push_back(mk(4'd0,  32'h0,        32'h12345678, 0, 32'h12345678, 32'h0,        1,  0, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(4'd2,  32'hFFFFFFFF, 32'h00000000, 1, 32'h00000000, 32'h0,        1,  0, 4'b1001, 4'b1111, 0));
      vecs.push_back(mk(4'd3,  32'h80000000, 32'h00000001, 0, 32'h7FFFFFFF, 32'h0,        1,  0, 4'b0100, 4'b1111, 0));
      vecs.push_back(mk(4'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 32'h0,        1,  0, 4'b0000, 4'b0111, 0));
      vecs.push_back(mk(4'd6,  32'h0,        32'h0,        0, 32'h00000000, 32'h0,        1,  0, 4'b0001, 4'b0111, 0));
      vecs.push_back(mk(4'd7,  32'hFFFF0000, 32'h0000FFFF, 0, 32'hFFFFFFFF, 32'h0,        1,  0, 4'b0010, 4'b0111, 0));
      vecs.push_back(mk(4'd8,  32'hC0000001, 32'h00000021, 0, 32'h80000002, 32'h0,        1,  0, 4'b1010, 4'b1111, 0));
      vecs.push_back(mk(4'd9,  32'h00000003, 32'h00000000, 0, 32'h00000003, 32'h0,        1,  0, 4'b0000, 4'b1111, 0));
      vecs.push_back(mk(4'd9,  32'hC0000000, 32'h0000001F, 0, 32'h00000001, 32'h0,        1,  0, 4'b1000, 4'b1111, 0));
      vecs.push_back(mk(4'd11, 32'hFFFFFFFE, 32'h00000003, 0, 32'hFFFFFFFA, 32'hFFFFFFFF, 1,  1, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(4'd11, 32'h00010000, 32'h00010000, 0, 32'h00000000, 32'h00000001, 1,  1, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(4'd14, 32'h11111111, 32'h22222222, 0, 32'h0,        32'h0,        0,  0, 4'b0000, 4'b0000, 1));
      vecs.push_back(mk(4'd15, 32'h33333333, 32'h44444444, 1, 32'h0,        32'h0,        0,  0, 4'b0000, 4'b0000, 1));
`ifdef EXEC_DIV_EN
      vecs.push_back(mk(4'd12, 32'h00000009, 32'h00000000, 0, 32'h00000000, 32'h00000009, 1,  1, 4'b0101, 4'b0111, 0));
      vecs.push_back(mk(4'd12, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 32'h00000000, 1,  1, 4'b0110, 4'b0111, 0));
      vecs.push_back(mk(4'd13, 32'h00000005, 32'h00000000, 0, 32'h00000000, 32'h00000005, 1,  1, 4'b0101, 4'b0111, 0));
`else
      vecs.push_back(mk(4'd12, 32'h00000009, 32'h00000000, 0, 32'h0,        32'h0,        0,  0, 4'b0000, 4'b0000, 1));
      vecs.push_back(mk(4'd12, 32'hFFFFFFF9, 32'h00000002, 0, 32'h0,        32'h0,        0,  0, 4'b0000, 4'b0000, 1));
      vecs.push_back(mk(4'd13, 32'h00000064, 32'h00000007, 0, 32'h0,        32'h0,        0,  0, 4'b0000, 4'b0000, 1));
`endif

      foreach (vecs[i]) begin
         logic [4:0] d, d2;
         d = 5'(i);
         d2 = ~5'(i);
         issue(vecs[i].op, vecs[i].opb, vecs[i].opa, vecs[i].cin, d, d2);
         check_out($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].r, vecs[i].r2, vecs[i].we,
                   vecs[i].we2, vecs[i].fl, vecs[i].fwe, vecs[i].ill, d, d2);
         check("busy single-cycle", 64'(busy), 64'd0);
      end

      // Writeback stall: output holds, stage refuses new work.
      issue(4'd10, 32'h80000001, 32'h00000001, 1'b0, 5'd7, 5'd8);
      out_ready = 1'b0;
      in_valid = 1'b1; op = 4'd0; opa = 32'h5555_5555;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("stall out_valid", 64'(out_valid), 64'd1);
         check("stall result", 64'(result), 64'hC0000000);
         check("stall flags_o", 64'(flags_o), 64'b1010);
         check("stall out_dst", 64'(out_dst), 64'd7);
         check("stall in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall release out_valid", 64'(out_valid), 64'd0);

`ifdef EXEC_DIV_EN
      run_div("div -7/2", 4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b0010);
      run_div("divu 100/7", 4'd13, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
      run_div("div 7/-2", 4'd12, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 4'b0010);
      run_div("divu 0/3", 4'd13, 32'd0, 32'd3, 32'd0, 32'd0, 4'b0001);

      // Reset in the middle of a division abandons it.
      issue(4'd13, 32'd100, 32'd7, 1'b0, 5'd1, 5'd2);
      repeat (10) @(posedge clk);
      #1;
      check("mid-div busy", 64'(busy), 64'd1);
`else
      issue(4'd12, 32'hFFFFFFF9, 32'h00000002, 1'b0, 5'd1, 5'd2);
      check("div disabled busy", 64'(busy), 64'd0);
      check_out("div disabled", 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 5'd1, 5'd2);
      repeat (4) @(posedge clk);
`endif
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid-div reset out_valid", 64'(out_valid), 64'd0);
      check("mid-div reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) stale++;
      end
      check("no stale output after reset", 64'(stale), 64'd0);
      issue(4'd11, 32'hFFFFFFFE, 32'h00000003, 1'b0, 5'd9, 5'd10);
      check("post-reset mul product", {result2, result}, 64'hFFFFFFFF_FFFFFFFA);
      check_out("post-reset mul", 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b1, 4'b0000, 4'b0000,
                1'b0, 5'd9, 5'd10);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
